// File: rtl/config_loader.sv
// config_loader: clears a daisy-chained config shift chain, then streams host words into it LSB first
module config_loader #(
    parameter int CHAIN_LENGTH = 36,
    parameter int WORD_WIDTH   = 8,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  chain_data_out,
    output logic                  chain_enable,
    output logic                  chain_nreset,
    input  logic                  chain_data_in,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam int BW = $clog2(CHAIN_LENGTH + 1);
    localparam int WB = $clog2(WORD_WIDTH + 1);
    localparam int CW = $clog2(CLEAR_CYCLES + 1);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLEAR = 3'd1;
    localparam logic [2:0] LOAD  = 3'd2;
    localparam logic [2:0] SHIFT = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    logic [2:0]            state;
    logic [WORD_WIDTH-1:0] shreg;
    logic [BW-1:0]         bit_count;
    logic [WB-1:0]         word_bits;
    logic [CW-1:0]         clr_cnt;
    assign word_ready     = state == LOAD;
    assign chain_enable   = state == SHIFT;
    assign chain_nreset   = state != CLEAR;
    assign chain_data_out = chain_enable & shreg[0];
    assign busy           = state == CLEAR || state == LOAD || state == SHIFT;
    assign done           = state == DONE;
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_count <= '0;
            word_bits <= '0;
            clr_cnt   <= '0;
            error     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state     <= CLEAR;
                    clr_cnt   <= '0;
                    bit_count <= '0;
                    error     <= 1'b0;
                end
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == CW'(CLEAR_CYCLES - 1)) state <= LOAD;
                end
                LOAD: if (word_valid) begin
                    shreg     <= word_data;
                    word_bits <= '0;
                    state     <= SHIFT;
                end
                SHIFT: begin
                    shreg     <= shreg >> 1;
                    bit_count <= bit_count + 1'b1;
                    word_bits <= word_bits + 1'b1;
                    // a cleared chain can only return zeros while we shift
                    if (chain_data_in) error <= 1'b1;
                    if (bit_count == BW'(CHAIN_LENGTH - 1)) state <= DONE;
                    else if (word_bits == WB'(WORD_WIDTH - 1)) state <= LOAD;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
